// File: rtl/counter_mode_ctrl.sv
// counter_mode_ctrl: programmable run controller (mode/limit, start/stop/pause, tc/done status).
// Define COUNTER_CTRL_PRESCALE_EN to step the count once every PRESCALE run cycles.
module counter_mode_ctrl #(
    parameter int WIDTH         = 4,
    parameter int DEFAULT_LIMIT = 9,
    parameter int PRESCALE      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_BOUNCE  = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_down_q, dir_down_d;

    logic tick;
    logic cfg_fire;
    logic at_limit;
    logic at_zero;
    logic at_terminal;

    assign cfg_ready = (state_q != RUN);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign count     = count_q;
    assign at_limit  = (count_q == limit_q);
    assign at_zero   = (count_q == '0);

`ifdef COUNTER_CTRL_PRESCALE_EN
    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign tick = (presc_q == PRESC_LAST);

    // Restart the step period on any fresh run or reconfiguration; hold while paused.
    always_comb begin
        presc_d = presc_q;
        if (cfg_fire || (state_q != RUN && state_d == RUN)) begin
            presc_d = '0;
        end else if (state_q == RUN && state_d == RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    // Without the prescaler every cycle is a tick (PRESCALE is only legal when >= 1).
    assign tick = (PRESCALE >= 1);
`endif

    always_comb begin
        at_terminal = at_limit;
        if (mode_q == MODE_DOWN || (mode_q == MODE_BOUNCE && dir_down_q)) begin
            at_terminal = at_zero;
        end
    end

    assign tc = busy && tick && at_terminal;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        limit_d    = limit_q;
        mode_d     = mode_q;
        dir_down_d = dir_down_q;

        case (state_q)
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    // A zero limit pins the count at 0 in every mode.
                    if (limit_q == '0) begin
                        count_d = '0;
                        if (mode_q == MODE_ONESHOT) begin
                            state_d = DONE;
                        end
                    end else begin
                        case (mode_q)
                            MODE_UP: begin
                                count_d = at_limit ? '0 : count_q + 1'b1;
                            end
                            MODE_DOWN: begin
                                count_d = at_zero ? limit_q : count_q - 1'b1;
                            end
                            MODE_ONESHOT: begin
                                if (at_limit) begin
                                    state_d = DONE;
                                end else begin
                                    count_d = count_q + 1'b1;
                                end
                            end
                            default: begin
                                if (!dir_down_q && at_limit) begin
                                    dir_down_d = 1'b1;
                                    count_d    = limit_q - 1'b1;
                                end else if (dir_down_q && at_zero) begin
                                    dir_down_d = 1'b0;
                                    count_d    = {{(WIDTH-1){1'b0}}, 1'b1};
                                end else if (dir_down_q) begin
                                    count_d = count_q - 1'b1;
                                end else begin
                                    count_d = count_q + 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            default: begin
                if (start) begin
                    state_d = RUN;
                end
            end
        endcase

        // A configuration load overrides any count reload made above.
        if (cfg_fire) begin
            mode_d     = cfg_mode;
            limit_d    = cfg_limit;
            dir_down_d = 1'b0;
            count_d    = (cfg_mode == MODE_DOWN) ? cfg_limit : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            limit_q    <= WIDTH'(DEFAULT_LIMIT);
            mode_q     <= MODE_UP;
            dir_down_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            limit_q    <= limit_d;
            mode_q     <= mode_d;
            dir_down_q <= dir_down_d;
        end
    end

endmodule

// File: tb/tb_counter_mode_ctrl.sv
// tb_counter_mode_ctrl: directed scoreboard bench for counter_mode_ctrl (WIDTH=4 defaults).
// Expected outputs are queued when each stimulus is driven and compared after the following edge.
`timescale 1ns/1ps
module tb_counter_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_mode = 2'b00;
    logic [3:0] cfg_limit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    // {busy, done, cfg_ready} per state
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_RUN  = 3'b100;
    localparam logic [2:0] ST_DONE = 3'b011;

    typedef struct {
        string      tag;
        logic [7:0] vec;
    } exp_t;

    exp_t scoreboard[$];
    int   vectors_applied = 0;
    int   miscompares = 0;

    logic [3:0] bounce_cnt[6] = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2};
    logic       bounce_tc[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    counter_mode_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_limit (cfg_limit),
        .start     (start),
        .stop      (stop),
        .count     (count),
        .tc        (tc),
        .busy      (busy),
        .done      (done)
    );

    task automatic checkOutput();
        exp_t       e;
        logic [7:0] obs;
        obs = {count, tc, busy, done, cfg_ready};
        e = scoreboard.pop_front();
        vectors_applied++;
        assert (obs === e.vec) else begin
            miscompares++;
            $error("[TB] FAIL %s observed count=%0d tc=%b busy/done/rdy=%b expected count=%0d tc=%b busy/done/rdy=%b",
                   e.tag, obs[7:4], obs[3], obs[2:0], e.vec[7:4], e.vec[3], e.vec[2:0]);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic st, input logic sp, input logic cv,
                                 input logic [1:0] md, input logic [3:0] lm,
                                 input logic [3:0] exp_count, input logic exp_tc, input logic [2:0] exp_st);
        start     = st;
        stop      = sp;
        cfg_valid = cv;
        cfg_mode  = md;
        cfg_limit = lm;
        scoreboard.push_back('{tag, {exp_count, exp_tc, exp_st}});
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic run_step(input string tag, input logic [3:0] exp_count, input logic exp_tc);
        applyStimulus(tag, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, exp_count, exp_tc, ST_RUN);
    endtask

    // Reset is driven alongside start/cfg requests to show that it dominates them.
    task automatic reset_step(input string tag, input logic noisy);
        reset     = 1'b1;
        start     = noisy;
        stop      = 1'b0;
        cfg_valid = noisy;
        cfg_mode  = 2'b01;
        cfg_limit = 4'd5;
        scoreboard.push_back('{tag, {4'd0, 1'b0, ST_IDLE}});
        @(posedge clk);
        #1;
        checkOutput();
        reset     = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset_step("reset_state", 1'b0);
        reset_step("reset_dominant", 1'b1);

`ifdef COUNTER_CTRL_PRESCALE_EN
        applyStimulus("pre_cfg_start", 1, 0, 1, 2'b00, 4'd9, 4'd0, 1'b0, ST_RUN);
        for (int i = 1; i <= 41; i++) begin
            run_step("pre_count", 4'((i / 4) % 10), ((i / 4) == 9) && ((i % 4) == 3));
        end
        applyStimulus("pre_stop", 0, 1, 0, 2'b00, 4'd0, 4'd0, 1'b0, ST_IDLE);
`else
        // Mode 00 up-wrap, limit 9
        applyStimulus("m00_cfg", 0, 0, 1, 2'b00, 4'd9, 4'd0, 1'b0, ST_IDLE);
        applyStimulus("m00_start", 1, 0, 0, 2'b00, 4'd0, 4'd0, 1'b0, ST_RUN);
        for (int i = 1; i <= 11; i++) begin
            run_step("m00_count", 4'(i % 10), (i == 9));
        end
        applyStimulus("m00_stop", 0, 1, 0, 2'b00, 4'd0, 4'd1, 1'b0, ST_IDLE);

        // Mode 01 down-wrap, limit 5, config and start in the same cycle
        applyStimulus("m01_cfg_start", 1, 0, 1, 2'b01, 4'd5, 4'd5, 1'b0, ST_RUN);
        for (int i = 1; i <= 6; i++) begin
            run_step("m01_count", (i <= 5) ? 4'(5 - i) : 4'd5, (i == 5));
        end
        applyStimulus("m01_stop", 0, 1, 0, 2'b00, 4'd0, 4'd5, 1'b0, ST_IDLE);

        // Mode 10 one-shot, limit 3
        applyStimulus("m10_cfg", 0, 0, 1, 2'b10, 4'd3, 4'd0, 1'b0, ST_IDLE);
        applyStimulus("m10_start", 1, 0, 0, 2'b00, 4'd0, 4'd0, 1'b0, ST_RUN);
        for (int i = 1; i <= 3; i++) begin
            run_step("m10_count", 4'(i), (i == 3));
        end
        applyStimulus("m10_done", 0, 0, 0, 2'b00, 4'd0, 4'd3, 1'b0, ST_DONE);
        applyStimulus("m10_stop_ignored", 0, 1, 0, 2'b00, 4'd0, 4'd3, 1'b0, ST_DONE);
        applyStimulus("m10_restart", 1, 0, 0, 2'b00, 4'd0, 4'd0, 1'b0, ST_RUN);
        run_step("m10_recount", 4'd1, 1'b0);
        applyStimulus("m10_stop", 0, 1, 0, 2'b00, 4'd0, 4'd1, 1'b0, ST_IDLE);

        // Mode 11 bounce, limit 2
        applyStimulus("m11_cfg", 0, 0, 1, 2'b11, 4'd2, 4'd0, 1'b0, ST_IDLE);
        applyStimulus("m11_start", 1, 0, 0, 2'b00, 4'd0, 4'd0, 1'b0, ST_RUN);
        for (int i = 0; i < 6; i++) begin
            run_step("m11_count", bounce_cnt[i], bounce_tc[i]);
        end
        applyStimulus("m11_stop", 0, 1, 0, 2'b00, 4'd0, 4'd2, 1'b0, ST_IDLE);

        // Pause/resume, start+stop together, config ignored while running
        applyStimulus("pause_cfg", 0, 0, 1, 2'b00, 4'd9, 4'd0, 1'b0, ST_IDLE);
        applyStimulus("pause_start", 1, 0, 0, 2'b00, 4'd0, 4'd0, 1'b0, ST_RUN);
        for (int i = 1; i <= 4; i++) begin
            run_step("pause_count", 4'(i), 1'b0);
        end
        applyStimulus("pause_stop", 0, 1, 0, 2'b00, 4'd0, 4'd4, 1'b0, ST_IDLE);
        applyStimulus("pause_resume", 1, 0, 0, 2'b00, 4'd0, 4'd4, 1'b0, ST_RUN);
        run_step("resume_count", 4'd5, 1'b0);
        run_step("resume_count", 4'd6, 1'b0);
        applyStimulus("start_stop_same", 1, 1, 0, 2'b00, 4'd0, 4'd6, 1'b0, ST_IDLE);
        applyStimulus("restart", 1, 0, 0, 2'b00, 4'd0, 4'd6, 1'b0, ST_RUN);
        applyStimulus("cfg_in_run", 0, 0, 1, 2'b01, 4'd2, 4'd7, 1'b0, ST_RUN);
        for (int i = 8; i <= 17; i++) begin
            run_step("after_cfg_in_run", 4'(i % 10), (i == 9));
        end

        // Reset at count 7 mid-run, then default limit 9 and mode 00
        reset_step("reset_mid_run", 1'b1);
        applyStimulus("default_start", 1, 0, 0, 2'b00, 4'd0, 4'd0, 1'b0, ST_RUN);
        for (int i = 1; i <= 10; i++) begin
            run_step("default_count", 4'(i % 10), (i == 9));
        end
        applyStimulus("default_stop", 0, 1, 0, 2'b00, 4'd0, 4'd0, 1'b0, ST_IDLE);

        // Limit 0 one-shot, then reconfiguration while DONE
        applyStimulus("lim0_m10", 1, 0, 1, 2'b10, 4'd0, 4'd0, 1'b1, ST_RUN);
        applyStimulus("lim0_m10_done", 0, 0, 0, 2'b00, 4'd0, 4'd0, 1'b0, ST_DONE);
        applyStimulus("done_cfg", 0, 0, 1, 2'b01, 4'd4, 4'd4, 1'b0, ST_DONE);
        applyStimulus("done_start", 1, 0, 0, 2'b00, 4'd0, 4'd0, 1'b1, ST_RUN);
        run_step("done_m01_count", 4'd4, 1'b0);
        run_step("done_m01_count", 4'd3, 1'b0);
        applyStimulus("done_m01_stop", 0, 1, 0, 2'b00, 4'd0, 4'd3, 1'b0, ST_IDLE);

        // Limit 0 bounce and up-wrap: count pinned at 0, tc every tick
        applyStimulus("lim0_m11", 1, 0, 1, 2'b11, 4'd0, 4'd0, 1'b1, ST_RUN);
        run_step("lim0_m11_hold", 4'd0, 1'b1);
        run_step("lim0_m11_hold", 4'd0, 1'b1);
        applyStimulus("lim0_m11_stop", 0, 1, 0, 2'b00, 4'd0, 4'd0, 1'b0, ST_IDLE);
        applyStimulus("lim0_m00", 1, 0, 1, 2'b00, 4'd0, 4'd0, 1'b1, ST_RUN);
        run_step("lim0_m00_hold", 4'd0, 1'b1);
        applyStimulus("lim0_m00_stop", 0, 1, 0, 2'b00, 4'd0, 4'd0, 1'b0, ST_IDLE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_mode_ctrl.md
Name: counter_mode_ctrl

Overview:
Run controller for the team's counter datapath: holds a programmed mode and limit, sequences start/stop/pause, and drives the count register plus terminal-count and done status. It sits between a host/config interface and the counter stage. It replaces ad-hoc free-running counters with one programmable, handshaked block.

Parameters:
WIDTH, 4, count and limit width in bits
DEFAULT_LIMIT, 9, limit register value after reset
PRESCALE, 4, cycles per count step; used only when the optional feature is compiled in (must be >= 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  config request
cfg_ready  output  1  config accepted when cfg_valid && cfg_ready
cfg_mode  input  2  00 up-wrap, 01 down-wrap, 10 one-shot up, 11 up/down bounce
cfg_limit  input  WIDTH  terminal value
start  input  1  run request (level sampled each cycle)
stop  input  1  pause request
count  output  WIDTH  current count (registered)
tc  output  1  terminal-count strobe
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset, synchronous, active-high, and dominant over all inputs: state=IDLE, count=0, mode=00, limit=DEFAULT_LIMIT, dir=up. Outputs: tc=0, busy=0, done=0, cfg_ready=1.
- States: IDLE, RUN, DONE. busy=(RUN), done=(DONE), cfg_ready=(IDLE or DONE).
- Config handshake:
  - Takes effect at the next edge: mode and limit registered, dir=up.
  - count loads limit for mode 01 and 0 for all other modes.
  - cfg_valid in RUN is ignored (cfg_ready=0). No state is changed.
- tick = 1 every cycle. See Optional Feature for the prescaled case.
- IDLE + start -> RUN. cfg handshake and start in the same cycle: both taken, and counting starts from the newly loaded value.
- RUN + stop -> IDLE. count holds its value (pause), and a later start resumes from it. start and stop together in RUN: stop wins.
- RUN, on tick:
  - mode 00: count = (count==limit) ? 0 : count+1
  - mode 01: count = (count==0) ? limit : count-1
  - mode 10: count+1 until count==limit. On that tick the state goes to DONE and count holds at limit.
  - mode 11: if dir=up and count==limit, dir=down and count=limit-1. If dir=down and count==0, dir=up and count=1. Otherwise step in dir.
- Counting has no overflow beyond limit, and arithmetic is mod 2^WIDTH. Limit 0: count stays 0 in all modes, and tc fires on every tick.
- tc is combinational from registered state: tc = RUN && tick && count at terminal.
  - Terminal is limit for modes 00, 10, and 11 with dir=up.
  - Terminal is 0 for mode 01 and 11 with dir=down.
  - Without prescale, tc is high in the cycle count shows the terminal value.
- DONE: count holds. start -> RUN with count reloaded to 0. A cfg handshake is allowed and reloads per the config rules. stop is ignored.
- Reset mid-RUN: the next cycle equals the post-reset state, with no tc.

Optional Feature:
Macro COUNTER_CTRL_PRESCALE_EN.
- Defined:
  - Adds a prescale counter over 0..PRESCALE-1, cleared by reset, by entry to RUN, and by a cfg handshake.
  - It advances only in RUN and holds while paused.
  - tick=1 only when the prescaler equals PRESCALE-1, so count steps once every PRESCALE RUN cycles, and tc is a one-cycle strobe on that tick.
- Undefined: the prescaler is absent, tick=1 constantly, and PRESCALE is unused.
- Port list is identical in both builds.

Test Plan:
All scenarios use WIDTH=4 and no macro unless stated.
- Reset; cfg mode 00 limit 9; start -> count 0,1,...,9,0,1. tc high only in cycles where count=9. busy=1, cfg_ready=0.
- cfg mode 01 limit 5; start -> count 5,4,3,2,1,0,5. tc high only when count=0.
- cfg mode 10 limit 3; start -> count 0,1,2,3, then DONE. done=1, busy=0, cfg_ready=1, count holds 3, one tc at 3. A second start gives 0,1,...
- cfg mode 11 limit 2; start -> count 0,1,2,1,0,1,2. tc at count 2 (dir up) and at count 0 (dir down), never at the initial 0.
- Mode 00 running; stop at count 4 -> IDLE with count 4; start -> 5,6. start+stop same cycle -> IDLE. cfg_valid during RUN -> no change.
- Reset asserted at count 7 in RUN -> next cycle count=0, IDLE, limit=9. With COUNTER_CTRL_PRESCALE_EN and PRESCALE=4: count steps every 4 cycles, and tc is exactly 1 cycle wide.
